mux_arbiter_8to1_32bit: RTL and testbench

MUX_ARBITER_8TO1_32BIT -- requirements
Module: mux_arbiter_8to1_32bit

---
 rtl/mux_arbiter_8to1_32bit_if.sv | 28 ++
 rtl/mux_arbiter_8to1_32bit.sv | 103 ++++++++++
 tb/tb_mux_arbiter_8to1_32bit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_8to1_32bit_if.sv
// Bus bundle for the 8-requester, 32-bit round-robin arbiter.
// master = requester/consumer side, slave = arbiter side.
interface mux_arbiter_8to1_32bit_if;
  logic [7:0]  Req;
  logic [31:0] In0;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [31:0] In3;
  logic [31:0] In4;
  logic [31:0] In5;
  logic [31:0] In6;
  logic [31:0] In7;
  logic        OutReady;
  logic [31:0] Out;
  logic        OutValid;
  logic [7:0]  Grant;
  logic [2:0]  Select;

  modport master (
    output Req, In0, In1, In2, In3, In4, In5, In6, In7, OutReady,
    input  Out, OutValid, Grant, Select
  );

  modport slave (
    input  Req, In0, In1, In2, In3, In4, In5, In6, In7, OutReady,
    output Out, OutValid, Grant, Select
  );
endinterface

// File: rtl/mux_arbiter_8to1_32bit.sv
// Round-robin 8:1 arbiter with a registered 32-bit output and valid/ready handoff.
// One transfer per two cycles at most; the winner's data is held until accepted.
module mux_arbiter_8to1_32bit (
  input  logic                    Clock,
  input  logic                    Reset,
  mux_arbiter_8to1_32bit_if.slave bus
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] select_q, select_d;

  logic [DW-1:0] in_arr [NREQ];
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] idx;

  assign in_arr[0] = bus.In0;
  assign in_arr[1] = bus.In1;
  assign in_arr[2] = bus.In2;
  assign in_arr[3] = bus.In3;
  assign in_arr[4] = bus.In4;
  assign in_arr[5] = bus.In5;
  assign in_arr[6] = bus.In6;
  assign in_arr[7] = bus.In7;

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      select_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      select_q <= select_d;
    end
  end

  // Next-state, winner search starting at the pointer, and next outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_d     = out_q;
    valid_d   = valid_q;
    grant_d   = '0;
    select_d  = select_q;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;

    for (int i = 0; i < int'(NREQ); i++) begin
      idx = ptr_q + IW'(i);
      if (!win_found && bus.Req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          out_d    = in_arr[win_idx];
          select_d = win_idx;
          grant_d  = NREQ'(1) << win_idx;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Completion edge: no arbitration here, pointer moves past the winner
        if (bus.OutReady) begin
          valid_d = 1'b0;
          ptr_d   = select_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Out      = out_q;
  assign bus.OutValid = valid_q;
  assign bus.Grant    = grant_q;
  assign bus.Select   = select_q;

endmodule

// File: tb/tb_mux_arbiter_8to1_32bit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level round-robin reference model.
module tb_mux_arbiter_8to1_32bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] tb_in [8];

  // reference model state
  bit          m_busy;
  int          m_ptr;
  int          m_sel;
  bit [31:0]   m_out;
  bit          m_valid;
  int          m_grant;

  mux_arbiter_8to1_32bit_if bus ();

  mux_arbiter_8to1_32bit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_in();
    bus.In0 = tb_in[0]; bus.In1 = tb_in[1]; bus.In2 = tb_in[2]; bus.In3 = tb_in[3];
    bus.In4 = tb_in[4]; bus.In5 = tb_in[5]; bus.In6 = tb_in[6]; bus.In7 = tb_in[7];
  endtask

  // Transaction-level reference: one call per clock edge
  task automatic model_edge(input logic [7:0] req, input logic ready, input logic r);
    m_grant = 0;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_sel = 0; m_out = 0; m_valid = 0;
    end else if (m_busy) begin
      if (ready) begin
        m_busy  = 0;
        m_valid = 0;
        m_ptr   = (m_sel + 1) % 8;
      end
    end else if (req != 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (req[c]) begin
          m_sel   = c;
          m_out   = tb_in[c];
          m_grant = 1 << c;
          m_valid = 1;
          m_busy  = 1;
          break;
        end
      end
    end
  endtask

  // Drive on the falling edge, clock once, then compare all outputs with the model
  task automatic step(input logic [7:0] req, input logic ready, input logic r);
    @(negedge clk);
    bus.Req      = req;
    bus.OutReady = ready;
    rst          = r;
    drive_in();
    @(posedge clk);
    model_edge(req, ready, r);
    #1;
    check("out",    bus.Out,             m_out);
    check("valid",  32'(bus.OutValid),   32'(m_valid));
    check("grant",  32'(bus.Grant),      32'(m_grant));
    check("select", 32'(bus.Select),     32'(m_sel));
  endtask

  int exp_idx;
  int pulses;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_busy = 0; m_ptr = 0; m_sel = 0; m_out = 0; m_valid = 0; m_grant = 0;
    for (int i = 0; i < 8; i++) tb_in[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1;
    bus.Req = '0;
    bus.OutReady = 1'b0;
    drive_in();

    // reset state
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    check("rst_out",   bus.Out, 32'h0);
    check("rst_grant", 32'(bus.Grant), 32'h0);

    // single request with one-cycle latency
    tb_in[0] = 32'hDEADBEEF;
    step(8'h01, 1'b1, 1'b0);
    check("single_out",   bus.Out, 32'hDEADBEEF);
    check("single_grant", 32'(bus.Grant), 32'h01);
    check("single_valid", 32'(bus.OutValid), 32'h1);
    step(8'h00, 1'b1, 1'b0);
    check("single_done_valid", 32'(bus.OutValid), 32'h0);
    check("single_done_grant", 32'(bus.Grant), 32'h0);

    // fairness: all requesting, selects rotate 0..7,0
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tb_in[i] = 32'(i);
    exp_idx = 0;
    for (int c = 0; c < 18; c++) begin
      step(8'hFF, 1'b1, 1'b0);
      if (c % 2 == 0) begin
        check("fair_sel",   32'(bus.Select), 32'(exp_idx % 8));
        check("fair_grant", 32'(bus.Grant), 32'(1) << (exp_idx % 8));
        check("fair_out",   bus.Out, 32'(exp_idx % 8));
        exp_idx++;
      end else begin
        check("fair_gap_grant", 32'(bus.Grant), 32'h0);
      end
    end

    // backpressure on requester 2
    step(8'h00, 1'b0, 1'b1);
    tb_in[2] = 32'hCAFE_0002;
    pulses = 0;
    step(8'h04, 1'b0, 1'b0);
    if (bus.Grant != 0) pulses++;
    for (int c = 0; c < 5; c++) begin
      step(8'h00, (c == 4) ? 1'b1 : 1'b0, 1'b0);
      if (bus.Grant != 0) pulses++;
      check("bp_out", bus.Out, 32'hCAFE_0002);
      check("bp_sel", 32'(bus.Select), 32'd2);
    end
    step(8'h00, 1'b1, 1'b0);
    check("bp_pulses", 32'(pulses), 32'd1);

    // wrap-around: after winner 5 the search is 6,7,0
    step(8'h00, 1'b0, 1'b1);
    step(8'h20, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h21, 1'b1, 1'b0);
    check("wrap_sel", 32'(bus.Select), 32'd0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    check("wrap_ptr1", 32'(bus.Select), 32'd1);
    step(8'h00, 1'b1, 1'b0);

    // reset while holding discards the transfer and restarts the pointer
    step(8'h10, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    check("rsthold_valid", 32'(bus.OutValid), 32'h0);
    check("rsthold_out",   bus.Out, 32'h0);
    step(8'h88, 1'b0, 1'b0);
    check("rsthold_win", 32'(bus.Select), 32'd3);
    step(8'h00, 1'b1, 1'b0);

    // idle cycles and reset colliding with requests
    for (int c = 0; c < 10; c++) step(8'h00, 1'($urandom_range(1)), 1'b0);
    check("idle_valid", 32'(bus.OutValid), 32'h0);
    step(8'hFF, 1'b1, 1'b1);
    check("rstreq_grant", 32'(bus.Grant), 32'h0);
    check("rstreq_valid", 32'(bus.OutValid), 32'h0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 8; i++) tb_in[i] = $urandom;
      step(8'($urandom), 1'($urandom_range(1)), ($urandom_range(49) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
